// File: rtl/dcache_wb_ctrl.sv
// Write-back/write-allocate D-cache controller: dirty-victim eviction, burst refill with critical-word capture, uncached bypass.
// Load hit completes in the request cycle; misses stall pipeline_ready while memory_valid is held until memory_ready.
module dcache_wb_ctrl #(
    parameter int WAYS       = 2,
    parameter int LINE_WORDS = 4,
    localparam int WAY_W     = (WAYS > 1) ? $clog2(WAYS) : 1,
    localparam int BEAT_W    = $clog2(LINE_WORDS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        is_dmem,
    input  logic              uncached,
    input  logic              hit,
    input  logic [WAY_W-1:0]  hit_way,
    input  logic [WAY_W-1:0]  victim_way,
    input  logic              victim_dirty,
    input  logic [BEAT_W-1:0] req_word,
    input  logic              memory_ready,
    output logic              memory_valid,
    output logic              memory_write,
    output logic              memory_uncached,
    output logic [BEAT_W-1:0] beat_idx,
    output logic              cache_we,
    output logic [WAY_W-1:0]  cache_way,
    output logic              is_data_from_mem,
    output logic              ret_we,
    output logic              dirty_set,
    output logic              dirty_clr,
    output logic              rbuf_we,
    output logic              en_r,
    output logic              pipeline_ready
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        WB     = 3'd1,
        REFILL = 3'd2,
        RESP   = 3'd3,
        ST_HIT = 3'd4,
        UNC    = 3'd5
    } state_t;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_WORDS - 1);
    localparam logic [BEAT_W-1:0] ONE_BEAT  = BEAT_W'(1);

    state_t            state, state_nxt;
    logic [BEAT_W-1:0] cnt, cnt_nxt;
    logic              op_store, op_store_nxt;
    logic [WAY_W-1:0]  way_q, way_nxt;

    logic is_store, is_load, req, last_beat;

    assign is_store  = is_dmem[1];
    assign is_load   = is_dmem[0];
    assign req       = is_store | is_load;
    assign last_beat = (cnt == LAST_BEAT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            op_store <= 1'b0;
            way_q    <= '0;
        end else begin
            state    <= state_nxt;
            cnt      <= cnt_nxt;
            op_store <= op_store_nxt;
            way_q    <= way_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        op_store_nxt = op_store;
        way_nxt      = way_q;
        case (state)
            IDLE: begin
                if (req) begin
                    if (uncached) begin
                        state_nxt = UNC;
                    end else if (hit) begin
                        // load hits retire in IDLE; only store hits need the array write cycle
                        if (is_store) begin
                            way_nxt      = hit_way;
                            op_store_nxt = 1'b1;
                            state_nxt    = ST_HIT;
                        end
                    end else begin
                        way_nxt      = victim_way;
                        op_store_nxt = is_store;
                        cnt_nxt      = '0;
                        state_nxt    = victim_dirty ? WB : REFILL;
                    end
                end
            end
            WB: begin
                if (memory_ready) begin
                    if (last_beat) begin
                        cnt_nxt   = '0;
                        state_nxt = REFILL;
                    end else begin
                        cnt_nxt = cnt + ONE_BEAT;
                    end
                end
            end
            REFILL: begin
                if (memory_ready) begin
                    if (last_beat) begin
                        cnt_nxt   = '0;
                        state_nxt = RESP;
                    end else begin
                        cnt_nxt = cnt + ONE_BEAT;
                    end
                end
            end
            RESP: begin
                // store misses merge the store data into the freshly refilled line
                state_nxt = op_store ? ST_HIT : IDLE;
            end
            ST_HIT: begin
                state_nxt = IDLE;
            end
            UNC: begin
                if (memory_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_comb begin
        memory_valid     = 1'b0;
        memory_write     = 1'b0;
        memory_uncached  = 1'b0;
        beat_idx         = '0;
        cache_we         = 1'b0;
        cache_way        = '0;
        is_data_from_mem = 1'b0;
        ret_we           = 1'b0;
        dirty_set        = 1'b0;
        dirty_clr        = 1'b0;
        rbuf_we          = 1'b0;
        en_r             = 1'b0;
        pipeline_ready   = 1'b0;
        if (!rst) begin
            beat_idx = cnt;
            case (state)
                IDLE: begin
                    if (!req) begin
                        rbuf_we = 1'b1;
                        en_r    = 1'b1;
                    end else if (!uncached && hit && is_load) begin
                        rbuf_we        = 1'b1;
                        en_r           = 1'b1;
                        pipeline_ready = 1'b1;
                    end
                end
                WB: begin
                    memory_valid = 1'b1;
                    memory_write = 1'b1;
                    cache_way    = way_q;
                    dirty_clr    = memory_ready & last_beat;
                end
                REFILL: begin
                    memory_valid = 1'b1;
                    cache_way    = way_q;
                    if (memory_ready) begin
                        cache_we         = 1'b1;
                        is_data_from_mem = 1'b1;
                        ret_we           = (cnt == req_word) & ~op_store;
                    end
                end
                RESP: begin
                    if (!op_store) begin
                        pipeline_ready = 1'b1;
                        rbuf_we        = 1'b1;
                        en_r           = 1'b1;
                    end
                end
                ST_HIT: begin
                    cache_we       = 1'b1;
                    cache_way      = way_q;
                    dirty_set      = 1'b1;
                    pipeline_ready = 1'b1;
                    rbuf_we        = 1'b1;
                    en_r           = 1'b1;
                end
                UNC: begin
                    memory_valid    = 1'b1;
                    memory_uncached = 1'b1;
                    memory_write    = is_store;
                    beat_idx        = '0;
                    if (memory_ready) begin
                        ret_we           = is_load;
                        is_data_from_mem = 1'b1;
                        pipeline_ready   = 1'b1;
                        rbuf_we          = 1'b1;
                        en_r             = 1'b1;
                    end
                end
                default: begin
                    beat_idx = '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dcache_wb_ctrl.sv
// Directed bench for dcache_wb_ctrl (WAYS=2, LINE_WORDS=4) with hand-derived output vectors.
module tb_dcache_wb_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] is_dmem;
    logic       uncached, hit, hit_way, victim_way, victim_dirty;
    logic [1:0] req_word;
    logic       memory_ready;
    logic       memory_valid, memory_write, memory_uncached;
    logic [1:0] beat_idx;
    logic       cache_we, cache_way, is_data_from_mem, ret_we;
    logic       dirty_set, dirty_clr, rbuf_we, en_r, pipeline_ready;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dcache_wb_ctrl #(.WAYS(2), .LINE_WORDS(4)) dut (
        .clk(clk), .rst(rst), .is_dmem(is_dmem), .uncached(uncached), .hit(hit),
        .hit_way(hit_way), .victim_way(victim_way), .victim_dirty(victim_dirty),
        .req_word(req_word), .memory_ready(memory_ready), .memory_valid(memory_valid),
        .memory_write(memory_write), .memory_uncached(memory_uncached), .beat_idx(beat_idx),
        .cache_we(cache_we), .cache_way(cache_way), .is_data_from_mem(is_data_from_mem),
        .ret_we(ret_we), .dirty_set(dirty_set), .dirty_clr(dirty_clr), .rbuf_we(rbuf_we),
        .en_r(en_r), .pipeline_ready(pipeline_ready)
    );

    // {mv,mw,mu,beat_idx[1:0],we,way,dfm,ret,dset,dclr,rbuf,en_r,pr}
    logic [14:0] obs;
    assign obs = {memory_valid, memory_write, memory_uncached, beat_idx, cache_we, cache_way,
                  is_data_from_mem, ret_we, dirty_set, dirty_clr, rbuf_we, en_r, pipeline_ready};

    function automatic logic [14:0] ev(input bit mv, mw, mu, input logic [1:0] bi,
                                       input bit we, way, dfm, rw, ds, dc, rb, en, pr);
        return {mv, mw, mu, bi, we, way, dfm, rw, ds, dc, rb, en, pr};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic look(input string tag, input logic [14:0] exp);
        #1;
        check_val(tag, 32'(obs), 32'(exp));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        is_dmem = 2'b00; uncached = 1'b0; hit = 1'b0; hit_way = 1'b0;
        victim_way = 1'b0; victim_dirty = 1'b0; req_word = 2'd0; memory_ready = 1'b0;
    endtask

    localparam logic [14:0] IDLE_V = 15'b000_00_0_0_0_0_0_0_1_1_0;
    localparam logic [14:0] ZERO_V = 15'b0;

    initial begin
        rst = 1'b1;
        idle_inputs();
        #2;
        look("reset_outputs", ZERO_V);
        step();
        rst = 1'b0;
        look("idle_after_reset", IDLE_V);

        // load hit: zero-wait completion, no memory traffic
        step();
        is_dmem = 2'b01; hit = 1'b1; hit_way = 1'b1;
        look("load_hit", ev(0,0,0,2'd0,0,0,0,0,0,0,1,1,1));
        step();
        idle_inputs();
        look("load_hit_stays_idle", IDLE_V);

        // store hit on way 1
        step();
        is_dmem = 2'b10; hit = 1'b1; hit_way = 1'b1;
        look("store_hit_idle", ZERO_V);
        step();
        look("store_hit_st", ev(0,0,0,2'd0,1,1,0,0,1,0,1,1,1));
        step();
        idle_inputs();
        look("store_hit_done", IDLE_V);

        // clean load miss, critical word 2, ready every cycle
        step();
        is_dmem = 2'b01; victim_way = 1'b0; hit_way = 1'b1; req_word = 2'd2; memory_ready = 1'b1;
        look("clean_miss_idle", ZERO_V);
        for (int i = 0; i < 4; i++) begin
            step();
            look($sformatf("clean_refill%0d", i), ev(1,0,0,2'(i),1,0,1,(i == 2),0,0,0,0,0));
        end
        step();
        look("clean_resp", ev(0,0,0,2'd0,0,0,0,0,0,0,1,1,1));
        step();
        idle_inputs();
        look("clean_done", IDLE_V);

        // dirty store miss into way 1, ready every second cycle
        step();
        is_dmem = 2'b10; victim_way = 1'b1; victim_dirty = 1'b1; req_word = 2'd2;
        look("dirty_miss_idle", ZERO_V);
        for (int i = 0; i < 4; i++) begin
            step();
            memory_ready = 1'b0;
            look($sformatf("wb_wait%0d", i), ev(1,1,0,2'(i),0,1,0,0,0,0,0,0,0));
            step();
            memory_ready = 1'b1;
            look($sformatf("wb_beat%0d", i), ev(1,1,0,2'(i),0,1,0,0,0,(i == 3),0,0,0));
        end
        for (int i = 0; i < 4; i++) begin
            step();
            memory_ready = 1'b0;
            look($sformatf("rf_wait%0d", i), ev(1,0,0,2'(i),0,1,0,0,0,0,0,0,0));
            step();
            memory_ready = 1'b1;
            look($sformatf("rf_beat%0d", i), ev(1,0,0,2'(i),1,1,1,0,0,0,0,0,0));
        end
        step();
        memory_ready = 1'b0;
        look("dirty_resp", ZERO_V);
        step();
        look("dirty_st_hit", ev(0,0,0,2'd0,1,1,0,0,1,0,1,1,1));
        step();
        idle_inputs();
        look("dirty_done", IDLE_V);

        // uncached load with hit asserted: bypass wins, ready after 3 wait cycles
        step();
        is_dmem = 2'b01; uncached = 1'b1; hit = 1'b1;
        look("unc_idle", ZERO_V);
        for (int i = 0; i < 3; i++) begin
            step();
            look($sformatf("unc_wait%0d", i), ev(1,0,1,2'd0,0,0,0,0,0,0,0,0,0));
        end
        step();
        memory_ready = 1'b1;
        look("unc_ready", ev(1,0,1,2'd0,0,0,1,1,0,0,1,1,1));
        step();
        idle_inputs();
        look("unc_done", IDLE_V);

        // uncached store, immediate ready
        step();
        is_dmem = 2'b10; uncached = 1'b1; memory_ready = 1'b1;
        look("uncst_idle", ZERO_V);
        step();
        look("uncst_ready", ev(1,1,1,2'd0,0,0,1,0,0,0,1,1,1));
        step();
        idle_inputs();
        look("uncst_done", IDLE_V);

        // reset in the middle of a refill burst
        step();
        is_dmem = 2'b01; req_word = 2'd3; memory_ready = 1'b1;
        step();
        step();
        step();
        look("pre_rst_beat2", ev(1,0,0,2'd2,1,0,1,0,0,0,0,0,0));
        rst = 1'b1;
        look("rst_mid_burst", ZERO_V);
        step();
        look("rst_held", ZERO_V);
        rst = 1'b0;
        req_word = 2'd0;
        look("post_rst_idle", ZERO_V);
        for (int i = 0; i < 4; i++) begin
            step();
            look($sformatf("fresh_refill%0d", i), ev(1,0,0,2'(i),1,0,1,(i == 0),0,0,0,0,0));
        end
        step();
        look("fresh_resp", ev(0,0,0,2'd0,0,0,0,0,0,0,1,1,1));
        step();
        idle_inputs();
        look("final_idle", IDLE_V);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
